// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared 640x480@60 Hz timing constants for the VGA sync generator and the
// snake renderer. Holds the default porch/sync widths, the derived line and
// frame totals, and the coordinate width used on pixel_x/pixel_y.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int FRAME_CYCLES_DEF = H_TOTAL_DEF * V_TOTAL_DEF;

endpackage

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Modulo-MODULUS up-counter used for both the horizontal and vertical
// position counters of vga_sync.
// Ports:
//   clock  - pixel clock
//   reset  - asynchronous, active-high; clears count to 0
//   inc    - advance the count this cycle
//   count  - current value, 0..MODULUS-1
//   wrap   - high when inc is set and count is at MODULUS-1 (next edge -> 0)
// -----------------------------------------------------------------------------
module mod_counter
  import vga_pkg::*;
#(
  parameter int MODULUS = H_TOTAL_DEF,
  parameter int WIDTH   = COORD_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic at_last;

  assign at_last = (count == LAST);
  assign wrap    = inc && at_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= at_last ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vga_sync.sv
// -----------------------------------------------------------------------------
// vga_sync
// Horizontal/vertical timing generator for the 640x480@60 Hz display path.
// Produces active-low hsync/vsync, the current pixel coordinates, a
// visible-area flag and per-line / per-frame ticks.
//
// Build option: VGA_SYNC_REG_OUT_EN
//   defined   - every output is registered (1-cycle latency from counters,
//               glitch-free)
//   undefined - outputs are combinational decodes of the counters; video_on
//               is forced low while reset is high
//
// Ports:
//   clock25    - 25 MHz pixel clock
//   reset      - asynchronous, active-high
//   hsync      - horizontal sync, active low
//   vsync      - vertical sync, active low
//   video_on   - high inside the visible area
//   pixel_x    - current column
//   pixel_y    - current line
//   line_tick  - one-cycle pulse on the last pixel of each line
//   frame_tick - one-cycle pulse on the last pixel of each frame
// -----------------------------------------------------------------------------
module vga_sync
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic               clock25,
  input  logic               reset,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               line_tick,
  output logic               frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  coord_t h_count;
  coord_t v_count;
  logic   h_wrap;
  logic   v_wrap;

  mod_counter #(
    .MODULUS (H_TOTAL),
    .WIDTH   (COORD_W)
  ) u_h_counter (
    .clock (clock25),
    .reset (reset),
    .inc   (1'b1),
    .count (h_count),
    .wrap  (h_wrap)
  );

  // The vertical counter only advances on the last pixel of a line, so its
  // wrap coincides with the horizontal wrap at (H_TOTAL-1, V_TOTAL-1).
  mod_counter #(
    .MODULUS (V_TOTAL),
    .WIDTH   (COORD_W)
  ) u_v_counter (
    .clock (clock25),
    .reset (reset),
    .inc   (h_wrap),
    .count (v_count),
    .wrap  (v_wrap)
  );

  logic hsync_d;
  logic vsync_d;
  logic video_d;
  logic line_d;
  logic frame_d;

  // Both sync decodes sit at the same logic depth from the counters, so the
  // hsync/vsync phase relationship does not depend on the build option.
  assign hsync_d = !((h_count >= HS_START) && (h_count <= HS_END));
  assign vsync_d = !((v_count >= VS_START) && (v_count <= VS_END));
  assign video_d = (h_count < H_VIS_C) && (v_count < V_VIS_C);
  assign line_d  = h_wrap;
  assign frame_d = v_wrap;

`ifdef VGA_SYNC_REG_OUT_EN

  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b0;
      pixel_x    <= '0;
      pixel_y    <= '0;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      hsync      <= hsync_d;
      vsync      <= vsync_d;
      video_on   <= video_d;
      pixel_x    <= h_count;
      pixel_y    <= v_count;
      line_tick  <= line_d;
      frame_tick <= frame_d;
    end
  end

`else

  // Counters reset to (0,0), which decodes as visible; gate video_on so the
  // renderer sees a blank screen for the whole reset interval.
  assign hsync      = hsync_d;
  assign vsync      = vsync_d;
  assign video_on   = video_d && !reset;
  assign pixel_x    = h_count;
  assign pixel_y    = v_count;
  assign line_tick  = line_d;
  assign frame_tick = frame_d;

`endif

endmodule

// File: tb/tb_vga_sync.sv
module tb_vga_sync;
  import vga_pkg::*;

`ifdef VGA_SYNC_REG_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  // reduced timing for frame-level checks
  localparam int SH_VIS = 16, SH_FP = 2, SH_SY = 4, SH_BP = 2;
  localparam int SV_VIS = 12, SV_FP = 2, SV_SY = 2, SV_BP = 3;
  localparam int SH_TOT = 24;
  localparam int SV_TOT = 19;
  localparam int SFRAME = 456;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #20 clk = ~clk;

  logic b_hs, b_vs, b_von, b_lt, b_ft;
  logic [9:0] b_x, b_y;
  logic s_hs, s_vs, s_von, s_lt, s_ft;
  logic [9:0] s_x, s_y;

  vga_sync u_big (
    .clock25    (clk),
    .reset      (rst),
    .hsync      (b_hs),
    .vsync      (b_vs),
    .video_on   (b_von),
    .pixel_x    (b_x),
    .pixel_y    (b_y),
    .line_tick  (b_lt),
    .frame_tick (b_ft)
  );

  vga_sync #(
    .H_VISIBLE (SH_VIS), .H_FRONT (SH_FP), .H_SYNC (SH_SY), .H_BACK (SH_BP),
    .V_VISIBLE (SV_VIS), .V_FRONT (SV_FP), .V_SYNC (SV_SY), .V_BACK (SV_BP)
  ) u_sml (
    .clock25    (clk),
    .reset      (rst),
    .hsync      (s_hs),
    .vsync      (s_vs),
    .video_on   (s_von),
    .pixel_x    (s_x),
    .pixel_y    (s_y),
    .line_tick  (s_lt),
    .frame_tick (s_ft)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rst(input string p, input logic hs, input logic vs,
                           input logic von, input logic lt, input logic ft,
                           input logic [9:0] x, input logic [9:0] y);
    check({p, "_hsync"},      int'(hs),  1);
    check({p, "_vsync"},      int'(vs),  1);
    check({p, "_video_on"},   int'(von), 0);
    check({p, "_line_tick"},  int'(lt),  0);
    check({p, "_frame_tick"}, int'(ft),  0);
    check({p, "_pixel_x"},    int'(x),   0);
    check({p, "_pixel_y"},    int'(y),   0);
  endtask

  initial begin
    int hs_low, hs_first, hs_falls, hs_mis, lt_n, lt_x, v_mis;
    int vs_low, vs_fx, vs_fy, vs_falls, vs_mis, von_n, ft_n, ft0, ft1, slt_n;
    int x, y;
    logic prev;
    bit found;

    // ---------------- reset state ----------------
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_rst("rst_big", b_hs, b_vs, b_von, b_lt, b_ft, b_x, b_y);
    check_rst("rst_sml", s_hs, s_vs, s_von, s_lt, s_ft, s_x, s_y);

    rst = 1'b0;
    @(negedge clk);
    check("first_edge_big_x", int'(b_x), 1 - LAT);
    check("first_edge_big_y", int'(b_y), 0);
    check("first_edge_big_von", int'(b_von), 1);

    // ---------------- one full line, default timing ----------------
    hs_low = 0; hs_first = -1; hs_falls = 0; hs_mis = 0;
    lt_n = 0; lt_x = -1; v_mis = 0; prev = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      x = int'(b_x);
      y = int'(b_y);
      if (!b_hs) begin
        if (hs_low == 0) hs_first = x;
        hs_low++;
      end
      if (prev && !b_hs) hs_falls++;
      prev = b_hs;
      if (b_hs !== !(x >= 656 && x <= 751)) hs_mis++;
      if (b_lt) begin
        lt_n++;
        lt_x = x;
      end
      if (b_von !== (x < 640 && y < 480)) v_mis++;
    end
    check("line_hs_low_cycles", hs_low, 96);
    check("line_hs_first_x", hs_first, 656);
    check("line_hs_pulses", hs_falls, 1);
    check("line_hs_decode_mis", hs_mis, 0);
    check("line_tick_count", lt_n, 1);
    check("line_tick_x", lt_x, 799);
    check("line_video_mis", v_mis, 0);

    // ---------------- frames, reduced timing ----------------
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (s_ft) found = 1'b1;
    end
    check("sml_ft_found", int'(found), 1);
    check("wrap_x", int'(s_x), SH_TOT - 1);
    check("wrap_y", int'(s_y), SV_TOT - 1);
    check("wrap_line_tick", int'(s_lt), 1);

    @(negedge clk);
    check("after_wrap_x", int'(s_x), 0);
    check("after_wrap_y", int'(s_y), 0);
    check("after_wrap_von", int'(s_von), 1);
    check("after_wrap_lt", int'(s_lt), 0);
    check("after_wrap_ft", int'(s_ft), 0);

    vs_low = 0; vs_fx = -1; vs_fy = -1; vs_falls = 0; vs_mis = 0;
    von_n = 0; ft_n = 0; ft0 = -1; ft1 = -1; slt_n = 0; prev = 1'b1;
    for (int i = 0; i < 2 * SFRAME; i++) begin
      y = int'(s_y);
      if (!s_vs) begin
        if (vs_low == 0) begin
          vs_fx = int'(s_x);
          vs_fy = y;
        end
        vs_low++;
      end
      if (prev && !s_vs) vs_falls++;
      prev = s_vs;
      if (s_vs !== !(y >= 14 && y <= 15)) vs_mis++;
      if (s_von) von_n++;
      if (s_lt) slt_n++;
      if (s_ft) begin
        if (ft_n == 0) ft0 = i;
        else if (ft_n == 1) ft1 = i;
        ft_n++;
      end
      @(negedge clk);
    end
    check("frame_tick_count", ft_n, 2);
    check("frame_tick_first_idx", ft0, SFRAME - 1);
    check("frame_tick_period", ft1 - ft0, SFRAME);
    check("frame_video_cycles", von_n, 2 * SH_VIS * SV_VIS);
    check("frame_vs_low_cycles", vs_low, 2 * SV_SY * SH_TOT);
    check("frame_vs_first_x", vs_fx, 0);
    check("frame_vs_first_y", vs_fy, 14);
    check("frame_vs_pulses", vs_falls, 2);
    check("frame_vs_decode_mis", vs_mis, 0);
    check("frame_line_ticks", slt_n, 2 * SV_TOT);

    // ---------------- asynchronous mid-frame reset ----------------
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (int'(s_x) == 10 && int'(s_y) == 5) found = 1'b1;
      else @(negedge clk);
    end
    check("mid_pos_found", int'(found), 1);
    #5;
    rst = 1'b1;
    #1;
    check_rst("async_sml", s_hs, s_vs, s_von, s_lt, s_ft, s_x, s_y);
    check_rst("async_big", b_hs, b_vs, b_von, b_lt, b_ft, b_x, b_y);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart_sml_x", int'(s_x), 1 - LAT);
    check("restart_sml_y", int'(s_y), 0);
    check("restart_big_x", int'(b_x), 1 - LAT);
    @(negedge clk);
    check("restart_sml_x2", int'(s_x), 2 - LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync.md
# vga_sync

Horizontal/vertical timing generator for the 640x480@60 Hz display path, clocked by the 25 MHz pixel clock produced by the clock divider stage. Drives active-low hsync/vsync to the VGA connector. Supplies current pixel coordinates and a visible-area flag to the snake renderer, plus a once-per-frame tick that paces game-state updates.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clock25  input  1  25 MHz pixel clock, from the clock divider; single clock domain
- reset  input  1  asynchronous, active-high; clears all state immediately
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- video_on  output  1  high while (pixel_x, pixel_y) is inside the visible area
- pixel_x  output  10  current column, 0..H_TOTAL-1
- pixel_y  output  10  current line, 0..V_TOTAL-1
- line_tick  output  1  one-cycle pulse on the last pixel of each line
- frame_tick  output  1  one-cycle pulse on the last pixel of each frame

## Operation
- H_TOTAL = sum of H_* (800 default); V_TOTAL = sum of V_* (525 default). Both counters are 10 bits unsigned.
- h_count increments every clock25 edge; wraps H_TOTAL-1 -> 0.
- v_count increments only when h_count == H_TOTAL-1; wraps V_TOTAL-1 -> 0 on the same edge h_count wraps.
- hsync = 0 for h_count in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751); else 1.
- vsync = 0 for v_count in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491); else 1.
- video_on = (h_count < H_VISIBLE) && (v_count < V_VISIBLE).
- line_tick = (h_count == H_TOTAL-1). frame_tick = line_tick && (v_count == V_TOTAL-1).
- pixel_x/pixel_y report h_count/v_count (shifted by the output stage, see Configuration).
- No enable; the generator free-runs whenever reset is low.

## Timing
- Reset asserted (any time, including mid-frame): h_count = v_count = 0 asynchronously. Outputs while reset is high: hsync = 1, vsync = 1, video_on = 0, pixel_x = 0, pixel_y = 0, line_tick = 0, frame_tick = 0.
- First rising edge after reset release: h_count 0 -> 1. Frame period is exactly H_TOTAL*V_TOTAL = 420000 cycles; line period is 800 cycles.
- Wrap-around: at (799,524) the next edge gives (0,0). frame_tick and line_tick are both high on that cycle.
- hsync and vsync have equal latency from the counters, so their relative phase is fixed regardless of configuration.

## Configuration
- VGA_SYNC_REG_OUT_EN defined: all outputs registered; each output reflects the counter state of the previous cycle (1-cycle latency). Outputs are glitch-free. Reset values are as listed above.
- Undefined: outputs are combinational decodes of the current counters (0 latency); video_on is gated low while reset is high.
- Counter behaviour, periods and reset values are identical in both builds.

## Structure
- Package vga_pkg holds the default timing constants, derived H_TOTAL/V_TOTAL, and the 10-bit coordinate width constant, shared with the renderer.
- One sub-module: mod_counter (parameter MODULUS; inputs clock, reset, inc; outputs count, wrap). It is instantiated twice: horizontal with inc = 1, vertical with inc = horizontal wrap.

## Test plan
- Release reset, run 1 line -> hsync low exactly 96 consecutive cycles starting at pixel_x = 656; line_tick high only at pixel_x = 799.
- Run 2 full frames -> frame_tick pulses exactly 420000 cycles apart; vsync low for exactly 1600 cycles starting at pixel_y = 490, pixel_x = 0.
- Count video_on cycles over one frame -> exactly 307200.
- Check wrap at (799,524) -> next cycle (0,0), video_on = 1, line_tick and frame_tick high on the wrap cycle only.
- Assert reset at pixel (300,200) mid-cycle -> outputs go to reset values without waiting for a clock edge; after release, counting restarts from (0,0).
- Repeat all scenarios with VGA_SYNC_REG_OUT_EN defined -> every output matches the undefined build delayed by exactly 1 cycle.
